// File: rtl/serial_borrow_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN, one bit per clock, LSB first,
// through a single full-subtractor cell with a registered borrow.
module serial_borrow_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             d_bit, brw_nxt, last;
    logic [WIDTH-1:0] res_nxt;

    // Full-subtractor cell on the current LSBs.
    assign d_bit   = a_sr[0] ^ b_sr[0] ^ brw;
    assign brw_nxt = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & brw) | (b_sr[0] & brw);
    assign res_nxt = (res_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    // Results are loaded on the final shift so they are already valid while DONE is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        brw    <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    brw    <= brw_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff <= res_nxt;
                        bout <= brw_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Bench for serial_borrow_subtractor at WIDTH 1, 4 and 8: directed vectors with
// literal expectations plus a cycle-level arithmetic model checked every cycle.
module tb_serial_borrow_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic       start_v [3];
    logic [7:0] a_v     [3];
    logic [7:0] b_v     [3];
    logic       bin_v   [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       bout_v  [3];
    logic [7:0] diff_v  [3];

    function automatic int wof(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 4 : 8);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : ch
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        logic [W-1:0] d_w;

        serial_borrow_subtractor #(.WIDTH(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .a     (a_v[g][W-1:0]),
            .b     (b_v[g][W-1:0]),
            .bin   (bin_v[g]),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .diff  (d_w),
            .bout  (bout_v[g])
        );
        assign diff_v[g] = 8'(d_w);

        // Model: an op accepted at edge acc occupies edges acc..acc+W, DONE after edge acc+W,
        // and the block accepts again from edge acc+W+2.
        int         n = 0;
        int         acc = 0;
        bit         active = 1'b0;
        logic [W:0] pend = '0;
        logic [W:0] held = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n = 0; acc = 0; active = 1'b0; pend = '0; held = '0;
            end else begin
                n++;
                if (active && n == acc + W) held = pend;
                if ((!active || n >= acc + W + 2) && start_v[g]) begin
                    acc    = n;
                    active = 1'b1;
                    pend   = {1'b0, a_v[g][W-1:0]} - {1'b0, b_v[g][W-1:0]} - (W+1)'(bin_v[g]);
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                logic exp_busy, exp_done;
                exp_busy = active && n >= acc && n <= acc + W;
                exp_done = active && n == acc + W;
                vectors++;
                if (busy_v[g] !== exp_busy || done_v[g] !== exp_done || {bout_v[g], d_w} !== held) begin
                    miscompares++;
                    $display("FAIL mon_w%0d edge %0d: busy/done/{bout,diff} got %b/%b/%h expected %b/%b/%h",
                             W, n, busy_v[g], done_v[g], {bout_v[g], d_w}, exp_busy, exp_done, held);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int g = 0; g < 3; g++)
            chk(nm, int'({busy_v[g], done_v[g], bout_v[g], diff_v[g]}), 0);
    endtask

    // One op on channel g; inputs are scrambled after acceptance to prove capture.
    task automatic run_op(input int g, input int av, input int bv, input int bi,
                          input int exp_d, input int exp_b, input string nm);
        int w;
        int k;
        bit seen;
        w = wof(g);
        @(negedge clk);
        a_v[g] = 8'(av); b_v[g] = 8'(bv); bin_v[g] = bi[0]; start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
        a_v[g] = 8'($urandom); b_v[g] = 8'($urandom); bin_v[g] = 1'($urandom);
        k = 1; seen = 1'b0;
        while (k <= w + 4) begin
            if (done_v[g]) begin seen = 1'b1; break; end
            @(negedge clk);
            k++;
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
        else begin
            chk({nm, "_lat"}, k, w + 1);
            chk({nm, "_diff"}, int'(diff_v[g]), exp_d);
            chk({nm, "_bout"}, int'(bout_v[g]), exp_b);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b0; a_v[g] = '0; b_v[g] = '0; bin_v[g] = 1'b0;
        end
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start_v[g] = 1'b1; a_v[g] = 8'hA5; b_v[g] = 8'h3C; bin_v[g] = 1'b1;
        end
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        chk_zero("reset_held");
        for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
        #2 rst_n = 1'b1;

        run_op(1, 9, 3, 0, 6, 0, "w4_9m3");
        run_op(1, 3, 9, 0, 4'hA, 1, "w4_3m9");
        run_op(1, 0, 0, 1, 4'hF, 1, "w4_0m0m1");
        run_op(0, 0, 1, 0, 1, 1, "w1_0m1");
        run_op(2, 8'h80, 8'h01, 1, 8'h7E, 0, "w8_80m1m1");

        // Abort mid-op: previous result (F,1) must vanish at once and no DONE follow.
        @(negedge clk);
        a_v[1] = 8'd9; b_v[1] = 8'd3; bin_v[1] = 1'b0; start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("abort");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_done", int'(done_v[1]), 0);
        run_op(1, 5, 7, 1, 4'hD, 1, "w4_after_abort");

        // Back-to-back with START held high across both ops.
        @(negedge clk);
        a_v[1] = 8'd1; b_v[1] = 8'd2; bin_v[1] = 1'b0; start_v[1] = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!done_v[1] && k < 12);
        chk("b2b_first_lat", k, 5);
        chk("b2b_first_res", int'({bout_v[1], diff_v[1][3:0]}), 5'h1F);
        a_v[1] = 8'd15; b_v[1] = 8'd15;
        k = 0;
        do begin @(negedge clk); k++; end while (!done_v[1] && k < 12);
        start_v[1] = 1'b0;
        chk("b2b_second_gap", k, 6);
        chk("b2b_second_res", int'({bout_v[1], diff_v[1][3:0]}), 0);
        repeat (8) @(negedge clk);

        for (int i = 0; i < 1000; i++) begin
            int g, w, av, bv, bi, t;
            g  = i % 3;
            w  = wof(g);
            av = int'($urandom_range(0, (1 << w) - 1));
            bv = int'($urandom_range(0, (1 << w) - 1));
            bi = int'($urandom_range(0, 1));
            t  = av - bv - bi;
            run_op(g, av, bv, bi, t & ((1 << w) - 1), (t < 0) ? 1 : 0, "rand");
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
